regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core; replaces the fixed 2-read/1-write, 32x32 file.
- Provides NUM_RD registered read ports and NUM_WR write ports.
- Write-to-read bypass within the same cycle.
- Per-register pending-write scoreboard, used by hazard detection.
- One debug tap register, default a0, for the testbench and top-level output.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 111 +++++++++++
 tb/tb_regfile_mp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Holds the default geometry of the core's integer file and the
// register/data types used by code that works at the default size.
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_ZERO  = 0;   // architectural index of x0
  localparam int REG_A0    = 10;  // architectural index of a0

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en_i        per-port writeback enables (clear the target's busy bit)
//   wr_addr_i      per-port writeback addresses, packed ADDR_W each
//   alloc_en_i     issue stage reserves a destination register
//   alloc_addr_i   register being reserved (sets its busy bit)
//   busy_d_o       scoreboard as it will be after this edge
//   busy_q_o       current scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  output logic [DEPTH-1:0]         busy_d_o,
  output logic [DEPTH-1:0]         busy_q_o
);

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  // Clears are applied before the set so that a producer issued in the
  // same cycle as an older producer's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) busy_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_d_o = busy_d;
  assign busy_q_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file.
// NUM_RD registered read ports with same-cycle write-to-read bypass,
// NUM_WR write ports (highest-numbered port wins on address conflict),
// a pending-write scoreboard and a combinational debug tap.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rd_addr      read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      registered read data, port i at [i*WIDTH +: WIDTH]
//   rd_busy      registered busy flag of each read address
//   wr_en        write enables, one per write port
//   wr_addr      write addresses, packed ADDR_W each
//   wr_data      write data, packed WIDTH each
//   alloc_en     reserve a destination register this cycle
//   alloc_addr   register being reserved
//   busy_vec     current scoreboard
//   dbg_q        stored value of register DBG_IDX (no bypass)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int DBG_IDX  = REG_A0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]  wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [DEPTH-1:0]         busy_vec,
  output logic [WIDTH-1:0]         dbg_q
);

  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);

  logic [WIDTH-1:0]        regs_q [DEPTH];
  logic [WIDTH-1:0]        rd_eff [NUM_RD];
  logic [NUM_RD*WIDTH-1:0] rd_data_q;
  logic [NUM_RD-1:0]       rd_busy_q;
  logic [DEPTH-1:0]        busy_d;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .busy_d_o     (busy_d),
    .busy_q_o     (busy_vec)
  );

  // Effective read value: stored data, overridden by any write landing on
  // the same edge. Later ports override earlier ones so the bypass agrees
  // with what storage will hold.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_eff[i] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
          rd_eff[i] = wr_data[j*WIDTH +: WIDTH];
      end
      if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))
        rd_eff[i] = '0;
    end
  end

  // Storage: loop order gives the highest-numbered port priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0)))
          regs_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*WIDTH +: WIDTH];
      end
    end
  end

  // Read stage: data and busy flag sampled together. The busy flag comes
  // from the post-edge scoreboard so it matches the data returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        rd_data_q[i*WIDTH +: WIDTH] <= rd_eff[i];
        rd_busy_q[i]                <= busy_d[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;
  assign dbg_q   = regs_q[DBG_A];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int D  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*W-1:0]  wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [D-1:0]     busy_vec;
  reg_data_t        dbg_q;

  regfile_mp #(
    .WIDTH (W), .DEPTH (D), .NUM_RD (NR), .NUM_WR (NW), .ZERO_REG (1), .DBG_IDX (10)
  ) dut (
    .clk (clk), .rst (rst),
    .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .alloc_en (alloc_en), .alloc_addr (alloc_addr),
    .busy_vec (busy_vec), .dbg_q (dbg_q)
  );

  always #5 clk = ~clk;

  // kinds of observation
  localparam int K_RDATA = 0;
  localparam int K_RBUSY = 1;
  localparam int K_BBIT  = 2;
  localparam int K_DBG   = 3;
  localparam int K_BVEC  = 4;

  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      K_RDATA: return rd_data[idx*W +: W];
      K_RBUSY: return {31'b0, rd_busy[idx]};
      K_BBIT:  return {31'b0, busy_vec[idx]};
      K_DBG:   return dbg_q;
      default: return busy_vec;
    endcase
  endfunction

  // Queue an expectation to be checked after the d-th rising edge from now.
  task automatic expect_at(int d, int kind, int idx, logic [31:0] exp, string name);
    chk_t c;
    c.due = cyc + d; c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  // Monitor: after each rising edge, compare every expectation due now.
  initial begin
    chk_t keep[$];
    logic [31:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      keep.delete();
      foreach (q[k]) begin
        if (q[k].due == cyc) begin
          act = observe(q[k].kind, q[k].idx);
          vectors++;
          if (act !== q[k].exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", q[k].name, act, q[k].exp, cyc);
          end
        end else if (q[k].due < cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL %s: check missed its cycle %0d", q[k].name, q[k].due);
        end else begin
          keep.push_back(q[k]);
        end
      end
      q = keep;
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*W +: W] = d;
  endtask

  task automatic rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic alloc(int a);
    alloc_en = 1'b1;
    alloc_addr = AW'(a);
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;

    // initial reset
    @(negedge clk);
    rst = 1'b1;
    expect_at(1, K_RDATA, 0, 32'h0, "rst_rdata0");
    expect_at(1, K_BVEC,  0, 32'h0, "rst_busyvec");
    expect_at(1, K_DBG,   0, 32'h0, "rst_dbg");

    // populate x5, x10 and reserve x5, then reset mid-operation
    next_cycle(); wr(0, 5, 32'hDEADBEEF); wr(1, 10, 32'h77); alloc(5);
    expect_at(1, K_BVEC, 0, 32'h0000_0020, "pre_rst_busy5");
    expect_at(1, K_DBG,  0, 32'h77,        "pre_rst_dbg");
    next_cycle(); rst = 1'b1; rd(0, 5); wr(0, 5, 32'h1); alloc(6);
    expect_at(1, K_RDATA, 0, 32'h0, "rst_mid_rdata");
    expect_at(1, K_BVEC,  0, 32'h0, "rst_mid_busyvec");
    expect_at(1, K_DBG,   0, 32'h0, "rst_mid_dbg");
    next_cycle(); rd(0, 5);
    expect_at(1, K_RDATA, 0, 32'h0, "rst_x5_cleared");

    // bypass
    next_cycle(); wr(0, 7, 32'h1234); rd(0, 7);
    expect_at(1, K_RDATA, 0, 32'h1234, "bypass_x7");
    next_cycle(); rd(1, 7);
    expect_at(1, K_RDATA, 1, 32'h1234, "stored_x7");

    // zero register
    next_cycle(); wr(0, 0, 32'hFFFFFFFF); rd(0, 0); rd(1, 0); alloc(0);
    expect_at(1, K_RDATA, 0, 32'h0, "zero_bypass_p0");
    expect_at(1, K_RDATA, 1, 32'h0, "zero_bypass_p1");
    expect_at(1, K_BBIT,  0, 32'h0, "zero_busy0");
    next_cycle(); rd(0, 0);
    expect_at(1, K_RDATA, 0, 32'h0, "zero_stored");

    // dual-write conflict: port 1 wins
    next_cycle(); wr(0, 3, 32'hAAAA); wr(1, 3, 32'h5555); rd(0, 3);
    expect_at(1, K_RDATA, 0, 32'h5555, "conflict_bypass");
    next_cycle(); rd(1, 3);
    expect_at(1, K_RDATA, 1, 32'h5555, "conflict_stored");
    next_cycle(); wr(0, 3, 32'h1111); wr(1, 4, 32'h2222); rd(0, 3); rd(1, 4);
    expect_at(1, K_RDATA, 0, 32'h1111, "dual_p0");
    expect_at(1, K_RDATA, 1, 32'h2222, "dual_p1");

    // scoreboard
    next_cycle(); alloc(9); rd(0, 9);
    expect_at(1, K_RBUSY, 0, 32'h1, "sb_alloc_same_edge");
    expect_at(1, K_BBIT,  9, 32'h1, "sb_busy9_set");
    next_cycle(); rd(0, 9);
    expect_at(1, K_RBUSY, 0, 32'h1, "sb_read_busy9");
    next_cycle(); wr(0, 9, 32'h99); alloc(9); rd(0, 9);
    expect_at(1, K_BBIT,  9, 32'h1,  "sb_set_wins");
    expect_at(1, K_RBUSY, 0, 32'h1,  "sb_set_wins_rbusy");
    expect_at(1, K_RDATA, 0, 32'h99, "sb_set_wins_data");
    next_cycle(); wr(0, 9, 32'h9A); rd(1, 9); alloc(12);
    expect_at(1, K_BBIT,  9, 32'h0,         "sb_clear9");
    expect_at(1, K_RBUSY, 1, 32'h0,         "sb_clear_rbusy");
    expect_at(1, K_RDATA, 1, 32'h9A,        "sb_clear_data");
    expect_at(1, K_BVEC,  0, 32'h0000_1000, "sb_vec_only12");
    next_cycle(); wr(1, 12, 32'h0C);
    expect_at(1, K_BVEC, 0, 32'h0, "sb_clear12_p1");

    // debug tap
    next_cycle(); wr(0, 10, 32'd42); rd(0, 10);
    expect_at(1, K_DBG,   0, 32'd42, "dbg_after_edge");
    expect_at(1, K_RDATA, 0, 32'd42, "dbg_rd_x10");
    next_cycle(); wr(0, 11, 32'h55); wr(1, 11, 32'h66);
    expect_at(1, K_DBG, 0, 32'd42, "dbg_unchanged_x11");
    next_cycle(); rd(0, 11);
    expect_at(1, K_RDATA, 0, 32'h66, "x11_port1_wins");
    expect_at(1, K_DBG,   0, 32'd42, "dbg_still_42");

    // drain outstanding expectations with a bounded wait
    next_cycle();
    for (int t = 0; t < 10 && q.size() != 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
